// File: rtl/clock_pkg.sv
// Shared types and helpers for the alarm controller that sits beside the
// 12-hour BCD clock counter.
package clock_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        RINGING = 2'd2,
        SNOOZE  = 2'd3
    } alarm_state_e;

    localparam logic [7:0] BCD_12 = 8'h12;
    localparam logic [7:0] BCD_59 = 8'h59;

    // Hours must be 01..09 or 10..12 and minutes 00..59, with each nibble a
    // legal decimal digit, so values such as 8'h0A or 8'h5A are rejected.
    function automatic logic bcd_time_valid(input logic [7:0] hh, input logic [7:0] mm);
        logic hh_ok;
        logic mm_ok;
        hh_ok = ((hh[7:4] == 4'd0) && (hh[3:0] >= 4'd1) && (hh[3:0] <= 4'd9)) ||
                ((hh >= 8'h10) && (hh <= BCD_12));
        mm_ok = (mm <= BCD_59) && (mm[3:0] <= 4'd9);
        return hh_ok && mm_ok;
    endfunction

endpackage

// File: rtl/alarm_time_cmp.sv
// Combinational compare of the running clock against the stored alarm time,
// plus the format check applied to a requested alarm time.
module alarm_time_cmp
    import clock_pkg::*;
(
    input  logic       pm,
    input  logic [7:0] hh,
    input  logic [7:0] mm,
    input  logic [7:0] ss,
    input  logic       alm_pm,
    input  logic [7:0] alm_hh,
    input  logic [7:0] alm_mm,
    input  logic [7:0] set_hh,
    input  logic [7:0] set_mm,
    output logic       time_eq,
    output logic       set_fmt_ok
);

    assign time_eq    = (pm == alm_pm) && (hh == alm_hh) && (mm == alm_mm) && (ss == 8'h00);
    assign set_fmt_ok = bcd_time_valid(set_hh, set_mm);

endmodule

// File: rtl/clock_alarm_ctrl.sv
// Alarm controller: stores the alarm time, rings when the clock reaches it,
// and handles snooze, stop, disarm and auto-silence.
module clock_alarm_ctrl
    import clock_pkg::*;
#(
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 540,
    parameter int MAX_SNOOZE  = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick,
    input  logic       pm,
    input  logic [7:0] hh,
    input  logic [7:0] mm,
    input  logic [7:0] ss,
    input  logic       arm_en,
    input  logic       set_valid,
    input  logic       set_pm,
    input  logic [7:0] set_hh,
    input  logic [7:0] set_mm,
    input  logic       snooze,
    input  logic       stop,
    output logic       ring,
    output logic       snoozing,
    output logic       armed,
    output logic       alm_pm,
    output logic [7:0] alm_hh,
    output logic [7:0] alm_mm,
    output logic       set_err
);

    localparam int RC_W = $clog2(RING_SECS + 1);
    localparam int SL_W = $clog2(SNOOZE_SECS + 1);
    localparam int SC_W = $clog2(MAX_SNOOZE + 1);

    localparam logic [RC_W-1:0] RING_LAST  = RC_W'(RING_SECS - 1);
    localparam logic [SL_W-1:0] SNOOZE_LD  = SL_W'(SNOOZE_SECS);
    localparam logic [SC_W-1:0] SNOOZE_MAX = SC_W'(MAX_SNOOZE);

    alarm_state_e    state;
    alarm_state_e    state_nx;
    logic            tick_q;
    logic            time_eq;
    logic            set_fmt_ok;
    logic            set_ok;
    logic            match;
    logic            snooze_ok;
    logic [RC_W-1:0] ring_cnt;
    logic [SL_W-1:0] snooze_left;
    logic [SC_W-1:0] snz_cnt;

    alarm_time_cmp u_cmp (
        .pm         (pm),
        .hh         (hh),
        .mm         (mm),
        .ss         (ss),
        .alm_pm     (alm_pm),
        .alm_hh     (alm_hh),
        .alm_mm     (alm_mm),
        .set_hh     (set_hh),
        .set_mm     (set_mm),
        .time_eq    (time_eq),
        .set_fmt_ok (set_fmt_ok)
    );

    // The clock counter shows its new time one cycle after tick, so all
    // matching and second counting is keyed off the delayed tick.
    assign set_ok    = set_valid && set_fmt_ok;
    assign match     = tick_q && time_eq;
    assign snooze_ok = snooze && (snz_cnt < SNOOZE_MAX);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_q  <= 1'b0;
            alm_pm  <= 1'b0;
            alm_hh  <= BCD_12;
            alm_mm  <= 8'h00;
            set_err <= 1'b0;
        end else begin
            tick_q  <= tick;
            set_err <= set_valid && !set_fmt_ok;
            if (set_ok) begin
                alm_pm <= set_pm;
                alm_hh <= set_hh;
                alm_mm <= set_mm;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    // Disarm overrides everything; stop and a valid set both fall back to ARMED.
    always_comb begin
        state_nx = state;
        if (!arm_en) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    state_nx = ARMED;
                ARMED:   if (match) state_nx = RINGING;
                RINGING: begin
                    if (stop || set_ok)                          state_nx = ARMED;
                    else if (snooze_ok)                          state_nx = SNOOZE;
                    else if (tick_q && (ring_cnt == RING_LAST))  state_nx = ARMED;
                end
                SNOOZE: begin
                    if (stop || set_ok)                          state_nx = ARMED;
                    else if (tick_q && (snooze_left == SL_W'(1))) state_nx = RINGING;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ring_cnt    <= '0;
            snooze_left <= '0;
            snz_cnt     <= '0;
        end else begin
            if (state == ARMED && state_nx == RINGING) begin
                ring_cnt <= '0;
                snz_cnt  <= '0;
            end else if (state == RINGING && state_nx == SNOOZE) begin
                snz_cnt     <= snz_cnt + 1'b1;
                snooze_left <= SNOOZE_LD;
            end else if (state == RINGING && state_nx == RINGING && tick_q) begin
                ring_cnt <= ring_cnt + 1'b1;
            end else if (state == SNOOZE && state_nx == SNOOZE && tick_q) begin
                snooze_left <= snooze_left - 1'b1;
            end else if (state == SNOOZE && state_nx == RINGING) begin
                ring_cnt    <= '0;
                snooze_left <= '0;
            end
        end
    end

    always_comb begin
        ring     = (state == RINGING);
        snoozing = (state == SNOOZE);
        armed    = (state != IDLE);
    end

endmodule

// File: doc/clock_alarm_ctrl.md
Name: clock_alarm_ctrl

Overview:
- Alarm controller downstream of the 12-hour BCD clock counter; consumes its pm/hh/mm/ss outputs and the same one-second enable that advances it.
- Holds a programmable alarm time and raises `ring` when the clock reaches that time.
- Supports snooze, stop, disarm and auto-silence.
- Drives the buzzer driver and front-panel status LEDs.

Parameters:
- RING_SECS, 60, number of seconds `ring` stays high before auto-silencing.
- SNOOZE_SECS, 540, number of seconds in SNOOZE before ringing resumes.
- MAX_SNOOZE, 3, number of snoozes accepted per alarm event; further snoozes are ignored.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset_n  input  1  asynchronous active-low reset
- tick  input  1  one-second enable, the same signal driving the clock counter's ena
- pm  input  1  clock PM flag
- hh  input  8  clock hours, BCD 01..12
- mm  input  8  clock minutes, BCD 00..59
- ss  input  8  clock seconds, BCD 00..59
- arm_en  input  1  level; alarm armed while high
- set_valid  input  1  single-cycle strobe; load alarm time
- set_pm  input  1  alarm PM flag
- set_hh  input  8  alarm hours, BCD
- set_mm  input  8  alarm minutes, BCD
- snooze  input  1  single-cycle strobe
- stop  input  1  single-cycle strobe
- ring  output  1  buzzer drive
- snoozing  output  1  high in SNOOZE
- armed  output  1  high in any state except IDLE
- alm_pm  output  1  stored alarm PM flag
- alm_hh  output  8  stored alarm hours
- alm_mm  output  8  stored alarm minutes
- set_err  output  1  one-cycle pulse on a rejected set

Behaviour:
- Reset (reset_n low, asynchronous):
  - state = IDLE.
  - alm_pm = 0, alm_hh = 8'h12, alm_mm = 8'h00 (12:00 AM).
  - ring, snoozing, armed, set_err = 0; all counters = 0.
- Time sampling:
  - The clock counter updates on the edge where tick = 1, so its new value is visible one cycle later.
  - Register tick_q <= tick. All time comparisons and second counting use tick_q.
- Match: tick_q && pm == alm_pm && hh == alm_hh && mm == alm_mm && ss == 8'h00.
- Set:
  - On set_valid with set_hh in BCD 01..09 or 10..12 and set_mm BCD 00..59 (each nibble checked), load alm_* next cycle.
  - Otherwise leave alm_* unchanged and pulse set_err for one cycle.
  - A valid set while in RINGING or SNOOZE returns the FSM to ARMED. A valid set does not change IDLE or ARMED.
- FSM states: IDLE, ARMED, RINGING, SNOOZE. Outputs are registered from state: ring = (state == RINGING), snoozing = (state == SNOOZE).
  - Any state, arm_en = 0 -> IDLE next cycle. This has highest priority, above set, stop and snooze.
  - IDLE, arm_en = 1 -> ARMED.
  - ARMED, match -> RINGING; ring_cnt = 0, snz_cnt = 0.
  - RINGING:
    - stop -> ARMED.
    - else snooze && snz_cnt < MAX_SNOOZE -> SNOOZE; snz_cnt++, snooze_left = SNOOZE_SECS.
    - else on tick_q, ring_cnt++. When ring_cnt reaches RING_SECS-1 on a tick_q -> ARMED.
  - SNOOZE:
    - stop -> ARMED.
    - else on tick_q, snooze_left--. On the tick_q where snooze_left == 1 -> RINGING with ring_cnt = 0.
    - snooze strobes in SNOOZE are ignored.
- Simultaneous events:
  - stop and snooze together: stop wins.
  - stop and valid set together: ARMED and alarm loaded.
  - match while in RINGING or SNOOZE does not restart anything.
- A snooze refused at MAX_SNOOZE has no effect; ringing continues.
- Counter widths: $clog2(RING_SECS+1), $clog2(SNOOZE_SECS+1), $clog2(MAX_SNOOZE+1).
- Reset asserted mid-ring drops ring asynchronously.

Decomposition:
- Shared package clock_pkg:
  - FSM state enum alarm_state_e.
  - BCD constants (BCD_12 = 8'h12, BCD_59 = 8'h59).
  - Function bcd_time_valid(hh, mm) used for set validation.
- One natural sub-module, alarm_time_cmp: combinational equality plus BCD validity check. Everything else stays in the top module.

Test Plan:
1. Reset, set 07:30 AM, arm_en = 1, run the clock from 07:29:58 AM with tick every 4 cycles -> ring rises 2 cycles after the tick that produces 07:30:00; stays high 60 ticks, then ARMED, ring = 0.
2. Ringing, pulse snooze -> ring = 0 and snoozing = 1 next cycle; after 540 ticks ring = 1 again. Three snoozes accepted; the 4th snooze leaves ring = 1.
3. set_hh = 8'h13, set_mm = 8'h00 -> set_err pulses 1 cycle, alm_hh stays 8'h12. set_mm = 8'h5A -> rejected likewise.
4. stop and snooze in the same cycle during RINGING -> ARMED, snoozing = 0.
5. Alarm 12:00 PM (set_pm = 1): clock at 12:00:00 AM -> no ring; at 12:00:00 PM -> ring.
6. Deassert arm_en during SNOOZE -> IDLE, armed = 0. Assert reset_n = 0 mid-ring between clock edges -> ring = 0 immediately, alarm reads 12:00 AM.
